// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the ID/EX boundary.
// Detects load-use hazards against the instruction in ID, flushes on a taken
// branch resolved in MEM, freezes the pipe while data memory is busy, and
// keeps a saturating count of cycles in which the PC was held.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_wait,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  // Multi-cycle stalls need the STALL state; a single bubble is handled in RUN
  // because the bubble itself clears ex_mem_read on the next cycle.
  localparam bit       MULTI   = (LOAD_STALL_CYCLES > 1);
  localparam logic [2:0] CNT_LD = 3'(LOAD_STALL_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       hazard;

  // Load in EX writes a register the ID instruction reads; $0 never hazards.
  always_comb begin
    hazard = ex_mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

  // State and remaining-bubble counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: memory wait freezes, branch flush aborts any stall.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!mem_wait) begin
      if (mem_branch_taken) begin
        state_nxt = RUN;
        cnt_nxt   = 3'd0;
      end else if (state == STALL) begin
        cnt_nxt = cnt - 3'd1;
        if (cnt <= 3'd1) state_nxt = RUN;
      end else if (hazard && MULTI) begin
        state_nxt = STALL;
        cnt_nxt   = CNT_LD;
      end
    end
  end

  // Mealy outputs: reset > mem_wait > branch flush > stall > normal flow.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (mem_wait) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (mem_branch_taken) begin
      flush = 1'b1;
    end else if ((state == STALL) || hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (!pc_write && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
